// File: rtl/pcpu_mem_pkg.sv
// Shared definitions for the pcpu memory responder: loader states, NOP word
// and default geometry.
package pcpu_mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // The CPU sees real instruction words only once it has been released.
  function automatic logic cpu_owns(input state_e s);
    return (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/pcpu_mem_ram.sv
// Single write port, single asynchronous read port word array.
// A read of the address being written returns the old word.
module pcpu_mem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; a reset of every word would turn it
  // into flops. Zeroing is done word by word by the owner's CLEAR sequence.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pcpu_mem.sv
// Memory-side responder for pcpu: instruction and data memories, plus a host
// loader FSM that clears, preloads and then releases the CPU.
module pcpu_mem
  import pcpu_mem_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_dataout,
  output logic [DATA_W-1:0] d_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_go,
  input  logic              ld_stop,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CLR_LAST    = '1;
  localparam state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  logic              imem_we, dmem_we;
  logic [ADDR_W-1:0] imem_waddr, dmem_waddr;
  logic [DATA_W-1:0] imem_wdata, dmem_wdata;
  logic [DATA_W-1:0] imem_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ld_ready    = 1'b0;
    cpu_enable  = 1'b0;
    cpu_start   = 1'b0;
    busy        = 1'b0;

    unique case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        // The counter parks on the last address instead of wrapping.
        if (clr_cnt == CLR_LAST) state_nxt   = ST_LOAD;
        else                     clr_cnt_nxt = clr_cnt + 1'b1;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_go) state_nxt = ST_START;
      end
      ST_START: begin
        cpu_start  = 1'b1;
        cpu_enable = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_RUN: begin
        cpu_enable = 1'b1;
        if (ld_stop) state_nxt = ST_LOAD;
      end
      default: state_nxt = RESET_STATE;
    endcase

    // Outputs are defined while reset is held, whatever the old state was.
    if (reset) begin
      ld_ready   = 1'b0;
      cpu_enable = 1'b0;
      cpu_start  = 1'b0;
      busy       = CLEAR_ON_RESET;
    end
  end

  // Write-port ownership: clear sequencer, then host loader, then CPU stores.
  always_comb begin
    imem_we    = 1'b0;
    imem_waddr = ld_addr;
    imem_wdata = ld_wdata;
    dmem_we    = 1'b0;
    dmem_waddr = ld_addr;
    dmem_wdata = ld_wdata;

    unique case (state)
      ST_CLEAR: begin
        imem_we    = 1'b1;
        imem_waddr = clr_cnt;
        imem_wdata = '0;
        dmem_we    = 1'b1;
        dmem_waddr = clr_cnt;
        dmem_wdata = '0;
      end
      ST_LOAD: begin
        imem_we = ld_valid && !ld_sel;
        dmem_we = ld_valid &&  ld_sel;
      end
      ST_RUN: begin
        dmem_we    = d_we;
        dmem_waddr = d_addr;
        dmem_wdata = d_dataout;
      end
      default: ;
    endcase

    if (reset) begin
      imem_we = 1'b0;
      dmem_we = 1'b0;
    end
  end

  pcpu_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_imem (
    .clock (clock),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (i_addr),
    .rdata (imem_rdata)
  );

  pcpu_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dmem (
    .clock (clock),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (d_addr),
    .rdata (d_data)
  );

  // Until the CPU is released it fetches NOPs rather than half-loaded code.
  assign i_data = cpu_owns(state) ? imem_rdata : DATA_W'(NOP_WORD);

endmodule

// File: tb/tb_pcpu_mem.sv
// Scoreboard bench for pcpu_mem: stimulus queues expected outputs, a monitor
// on the falling edge pops and compares them.
module tb_pcpu_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  i_addr, d_addr, ld_addr;
  logic [15:0] i_data, d_data, d_dataout, ld_wdata;
  logic        d_we, ld_valid, ld_ready, ld_sel, ld_go, ld_stop;
  logic        cpu_enable, cpu_start, busy;

  typedef enum {SIG_IDATA, SIG_DDATA, SIG_READY, SIG_ENABLE, SIG_START, SIG_BUSY} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clock = ~clock;

  pcpu_mem dut (
    .clock      (clock),
    .reset      (reset),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_dataout  (d_dataout),
    .d_data     (d_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_sel     (ld_sel),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_go      (ld_go),
    .ld_stop    (ld_stop),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, need %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [15:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        SIG_IDATA:  act = i_data;
        SIG_DDATA:  act = d_data;
        SIG_READY:  act = {15'b0, ld_ready};
        SIG_ENABLE: act = {15'b0, cpu_enable};
        SIG_START:  act = {15'b0, cpu_start};
        SIG_BUSY:   act = {15'b0, busy};
        default:    act = 'x;
      endcase
      check(e.name, act, e.exp);
    end
  end

  task automatic exp_push(input string name, input sig_e sig, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full 256-cycle clear; with disturb set, host/CPU traffic is thrown at it.
  task automatic clear_phase(input string tag, input bit disturb);
    for (int i = 0; i < 256; i++) begin
      if (disturb && i == 10) begin
        ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'h05; ld_wdata = 16'h1111;
        ld_go = 1'b1; d_we = 1'b1; d_addr = 8'h06; d_dataout = 16'h2222;
      end else if (disturb && i == 11) begin
        ld_valid = 1'b0; ld_go = 1'b0; d_we = 1'b0;
      end
      exp_push({tag, "_busy"}, SIG_BUSY, 16'h1);
      if (i == 0 || i == 255) exp_push({tag, "_ready_low"}, SIG_READY, 16'h0);
      tick();
    end
    exp_push({tag, "_busy_done"}, SIG_BUSY, 16'h0);
    exp_push({tag, "_ready_up"}, SIG_READY, 16'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; i_addr = '0; d_addr = '0; d_we = 1'b0; d_dataout = '0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_wdata = '0;
    ld_go = 1'b0; ld_stop = 1'b0;

    tick();
    exp_push("rst_busy",   SIG_BUSY,   16'h1);
    exp_push("rst_ready",  SIG_READY,  16'h0);
    exp_push("rst_enable", SIG_ENABLE, 16'h0);
    exp_push("rst_start",  SIG_START,  16'h0);
    tick();
    reset = 1'b0;

    clear_phase("clr1", 1'b0);

    // LOAD: preload words, dropped CPU write, go
    d_addr = 8'hFF; exp_push("clr1_top_word", SIG_DDATA, 16'h0000);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 8'h00; ld_wdata = 16'h0810;
    tick();
    ld_sel = 1'b1; ld_wdata = 16'h00AB;
    tick();
    ld_valid = 1'b0; d_we = 1'b1; d_addr = 8'h05; d_dataout = 16'h1234;
    exp_push("load_ready", SIG_READY, 16'h1);
    tick();
    d_we = 1'b0; exp_push("load_dwe_dropped", SIG_DDATA, 16'h0000);
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'hC8; ld_wdata = 16'h5A5A;
    tick();
    ld_valid = 1'b0; d_addr = 8'hC8; exp_push("load_dmem200", SIG_DDATA, 16'h5A5A);
    i_addr = 8'h00; exp_push("load_nop", SIG_IDATA, 16'h0000);
    ld_go = 1'b1;
    exp_push("load_no_start", SIG_START, 16'h0);
    exp_push("load_no_enable", SIG_ENABLE, 16'h0);
    tick();

    // START
    ld_go = 1'b0;
    exp_push("start_pulse", SIG_START, 16'h1);
    exp_push("start_enable", SIG_ENABLE, 16'h1);
    exp_push("start_ready", SIG_READY, 16'h0);
    exp_push("start_fetch0", SIG_IDATA, 16'h0810);
    d_addr = 8'h00; exp_push("start_dmem0", SIG_DDATA, 16'h00AB);
    tick();

    // RUN: store with read-during-write, host traffic ignored
    exp_push("run_start_low", SIG_START, 16'h0);
    exp_push("run_enable", SIG_ENABLE, 16'h1);
    d_we = 1'b1; d_addr = 8'h02; d_dataout = 16'h3CAB;
    exp_push("run_rdw_old", SIG_DDATA, 16'h0000);
    tick();
    d_we = 1'b0; exp_push("run_store_new", SIG_DDATA, 16'h3CAB);
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'h07; ld_wdata = 16'hFFFF; ld_go = 1'b1;
    exp_push("run_ready_low", SIG_READY, 16'h0);
    tick();
    ld_valid = 1'b0; ld_go = 1'b0; d_addr = 8'h07;
    exp_push("run_host_dropped", SIG_DDATA, 16'h0000);
    exp_push("run_go_ignored", SIG_START, 16'h0);
    exp_push("run_still_enabled", SIG_ENABLE, 16'h1);
    tick();
    d_we = 1'b1; d_addr = 8'h03; d_dataout = 16'hC0DE; ld_stop = 1'b1;
    exp_push("stop_cycle_enable", SIG_ENABLE, 16'h1);
    tick();
    d_we = 1'b0; ld_stop = 1'b0;
    exp_push("stop_write_kept", SIG_DDATA, 16'hC0DE);
    exp_push("stop_enable_low", SIG_ENABLE, 16'h0);
    exp_push("stop_ready", SIG_READY, 16'h1);
    exp_push("stop_nop", SIG_IDATA, 16'h0000);
    tick();
    ld_stop = 1'b1;
    tick();
    ld_stop = 1'b0;
    exp_push("load_stop_ignored", SIG_READY, 16'h1);
    exp_push("load_stop_enable", SIG_ENABLE, 16'h0);
    tick();

    // Reset into CLEAR, then reset again at clear cycle 100
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 0 || i == 99) exp_push("clr2_busy", SIG_BUSY, 16'h1);
      tick();
    end
    reset = 1'b1;
    exp_push("midclr_rst_busy", SIG_BUSY, 16'h1);
    exp_push("midclr_rst_ready", SIG_READY, 16'h0);
    tick();
    reset = 1'b0;

    clear_phase("clr3", 1'b1);
    d_addr = 8'hC8; exp_push("clr3_dmem200", SIG_DDATA, 16'h0000);
    tick();
    d_addr = 8'h05; exp_push("clr3_host_ignored", SIG_DDATA, 16'h0000);
    tick();
    d_addr = 8'h06; exp_push("clr3_cpu_ignored", SIG_DDATA, 16'h0000);
    tick();
    d_addr = 8'h03; exp_push("clr3_dmem3", SIG_DDATA, 16'h0000);
    exp_push("clr3_ready", SIG_READY, 16'h1);
    tick();

    @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pcpu_mem.md
Name: pcpu_mem

Overview:
- Memory-side responder for the pipelined CPU (pcpu).
- Serves the instruction fetch port (i_addr -> instruction word) and the data port (d_addr / d_we / d_dataout -> read data).
- Includes a host-side loader FSM that clears both memories, accepts program/data preload words over a valid/ready handshake, then releases the CPU with an enable level and a one-cycle start pulse.
- Replaces hand-driven instruction/data stimulus in system-level benches and on the board.

Parameters:
ADDR_W, 8, address width of both memories (DEPTH = 2**ADDR_W)
DATA_W, 16, word width of instruction and data memory
CLEAR_ON_RESET, 1, 1 = zero both arrays after reset; 0 = skip CLEAR and go straight to LOAD

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
i_addr  in  ADDR_W  CPU instruction fetch address
i_data  out  DATA_W  instruction word to CPU i_datain
d_addr  in  ADDR_W  CPU data address
d_we  in  1  CPU data write enable
d_dataout  in  DATA_W  CPU store data
d_data  out  DATA_W  load data to CPU d_datain
ld_valid  in  1  host preload word valid
ld_ready  out  1  loader can accept a word
ld_sel  in  1  0 = instruction memory, 1 = data memory
ld_addr  in  ADDR_W  preload address
ld_wdata  in  DATA_W  preload word
ld_go  in  1  host request: start CPU
ld_stop  in  1  host request: halt CPU, return to LOAD
cpu_enable  out  1  CPU enable level
cpu_start  out  1  one-cycle CPU start pulse
busy  out  1  high while CLEAR is in progress

Behaviour:
- Reset (sync, high): state <= CLEAR if CLEAR_ON_RESET else LOAD; clr_cnt <= 0.
  - Output values during reset: ld_ready=0, cpu_enable=0, cpu_start=0, busy=CLEAR_ON_RESET.
  - Array contents are not reset directly; CLEAR zeroes them.
- CLEAR:
  - Each cycle writes 0 to imem[clr_cnt] and dmem[clr_cnt], then clr_cnt++.
  - After the clr_cnt = DEPTH-1 write, next state is LOAD. DEPTH = 256 gives exactly 256 CLEAR cycles.
  - busy=1, ld_ready=0. ld_go, ld_stop, ld_valid and d_we are ignored.
- LOAD:
  - ld_ready=1.
  - Transfer occurs when ld_valid && ld_ready. The word is written at the clock edge to imem (ld_sel=0) or dmem (ld_sel=1) at ld_addr.
  - ld_go=1 -> START; a transfer in the same cycle is still written.
  - ld_stop is ignored.
- START: lasts exactly one cycle. cpu_start=1, cpu_enable=1, ld_ready=0. Next state is RUN.
- RUN:
  - cpu_enable=1, ld_ready=0.
  - CPU store: d_we=1 writes d_dataout to dmem[d_addr] at the clock edge.
  - ld_stop=1 -> LOAD; cpu_enable is 0 from the next cycle. A CPU write in the stop cycle is still committed.
  - ld_go is ignored.
- Read paths (combinational, zero latency, matching pcpu fetch/load timing):
  - i_data = imem[i_addr] in START/RUN; otherwise 16'h0000 (NOP).
  - d_data = dmem[d_addr] in all states.
- Read-during-write to the same address returns the old word; the new word is visible the following cycle.
- CPU writes (d_we) outside RUN are dropped. Host and CPU never write in the same cycle by construction.
- Reset mid-CLEAR, mid-LOAD or in RUN returns to the reset state immediately; a partially cleared array is cleared again from address 0.
- Address wrap: addresses are ADDR_W bits and there is no out-of-range case. clr_cnt stops at DEPTH-1 and does not wrap.

Decomposition:
- Shared package / def header holds:
  - state encoding: CLEAR, LOAD, START, RUN
  - NOP word constant (16'h0000)
  - default ADDR_W / DATA_W
- Natural sub-module: pcpu_mem_ram, a single-write-port, single-async-read-port DEPTH x DATA_W array. It is instantiated twice (imem, dmem).
- Write-port muxing (clear / host / CPU) stays in the top.

Test Plan:
- Reset 2 cycles, CLEAR_ON_RESET=1 -> busy=1 for exactly 256 cycles, ld_ready rises on cycle 257; d_addr=8'hFF reads 16'h0000.
- LOAD: write imem[0]=16'h0810 and dmem[0]=16'h00AB; ld_go -> i_data=16'h0000 while in LOAD; cpu_start high exactly one cycle; cpu_enable stays 1; i_addr=0 then gives 16'h0810.
- RUN: d_we=1, d_addr=8'h02, d_dataout=16'h3CAB -> d_data at addr 2 is 16'h0000 that cycle and 16'h3CAB next cycle.
- d_we=1 during LOAD at addr 8'h05 with 16'h1234 -> dmem[5] stays 16'h0000. ld_valid while in RUN -> ld_ready=0 and no write occurs.
- RUN, ld_stop=1 with simultaneous d_we to addr 8'h03 -> write committed; cpu_enable=0 next cycle; ld_ready=1.
- Reset asserted at CLEAR cycle 100 -> clr_cnt restarts at 0; busy lasts a further 256 cycles after reset is released; dmem[200] previously loaded reads 0 afterwards.
